pipe_datapath: RTL and testbench

PIPE_DATAPATH -- requirements
Module: pipe_datapath

---
 rtl/pipe_datapath_if.sv | 26 ++
 rtl/pipe_datapath.sv | 119 +++++++++++
 tb/tb_pipe_datapath.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_datapath_if.sv
// Bundles the control, operand and result signals of pipe_datapath.
// The master side (controller or testbench) drives the controls and
// operands. The slave side (the datapath) drives the results.
interface pipe_datapath_if;
  logic        [4:0]  load;
  logic        [11:0] oe;
  logic        [1:0]  c1;
  logic        [1:0]  c2;
  logic        [3:0]  count;
  logic signed [7:0]  din_a;
  logic signed [7:0]  din_b;
  logic signed [9:0]  dout;
  logic               dout_valid;
  logic               err;
  logic        [2:0]  err_code;

  modport master (
    output load, oe, c1, c2, count, din_a, din_b,
    input  dout, dout_valid, err, err_code
  );

  modport slave (
    input  load, oe, c1, c2, count, din_a, din_b,
    output dout, dout_valid, err, err_code
  );
endinterface

// File: rtl/pipe_datapath.sv
// Two-ALU register datapath with five 10-bit registers, R0..R4.
// ALU1 feeds R0..R3 and ALU2 feeds R4.
// A sticky error monitor flags three conditions:
//   - contention on a one-hot operand select
//   - a write attempted with a no-op opcode
//   - an illegal controller step sequence
module pipe_datapath (
  input  logic          clk,
  input  logic          reset,
  pipe_datapath_if.slave bus
);
  typedef enum logic {SEQ_FIRST, SEQ_TRACK} seq_state_e;

  logic signed [9:0] r_q [5];
  logic signed [9:0] r_d [5];
  logic              dout_valid_q, dout_valid_d;
  logic        [2:0] err_code_q, err_code_d;
  seq_state_e        seq_q, seq_d;
  logic        [3:0] prev_q, prev_d;

  logic signed [9:0] a_ext, b_ext;
  logic signed [9:0] op1_a, op1_b, op2_a, op2_b;
  logic signed [9:0] alu1_y, alu2_y;
  logic              contention, nop1, nop2, r4_write, nop_err, seq_err;

  // AND-OR mux on a one-hot select.
  // An all-zero select yields 0.
  // A multi-hot select yields garbage, but such cycles never write.
  function automatic logic signed [9:0] pick(input logic [2:0] s,
                                             input logic signed [9:0] x,
                                             input logic signed [9:0] y,
                                             input logic signed [9:0] z);
    return ({10{s[0]}} & x) | ({10{s[1]}} & y) | ({10{s[2]}} & z);
  endfunction

  function automatic logic multi_hot(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Operand selection, both ALUs, and the write and error decision for this cycle
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    a_ext = {{2{bus.din_a[7]}}, bus.din_a};
    b_ext = {{2{bus.din_b[7]}}, bus.din_b};

    op1_a = pick(bus.oe[2:0],  r_q[0], r_q[1], a_ext);
    op1_b = pick(bus.oe[5:3],  r_q[0], r_q[1], b_ext);
    op2_a = pick(bus.oe[8:6],  r_q[2], r_q[3], r_q[4]);
    op2_b = pick(bus.oe[11:9], r_q[2], r_q[3] >>> 1, r_q[2] >>> 3);

    contention = multi_hot(bus.oe[2:0]) | multi_hot(bus.oe[5:3]) |
                 multi_hot(bus.oe[8:6]) | multi_hot(bus.oe[11:9]);
    nop1 = (bus.c1 == 2'b11);
    nop2 = (bus.c2 == 2'b11);

    unique case (bus.c1)
      2'b00:   alu1_y = op1_a[9] ? -op1_a : op1_a;
      2'b01:   alu1_y = (op1_a < op1_b) ? op1_a : op1_b;
      2'b10:   alu1_y = (op1_a > op1_b) ? op1_a : op1_b;
      default: alu1_y = op1_a;
    endcase

    unique case (bus.c2)
      2'b00:   alu2_y = op2_a + op2_b;
      2'b01:   alu2_y = op2_a - op2_b;
      2'b10:   alu2_y = (op2_a > op2_b) ? op2_a : op2_b;
      default: alu2_y = op2_a;
    endcase

    r_d = r_q;
    if (!contention) begin
      if (bus.load[0])          r_d[0] = nop1 ? a_ext : alu1_y;
      if (bus.load[1])          r_d[1] = nop1 ? b_ext : alu1_y;
      if (bus.load[2] && !nop1) r_d[2] = alu1_y;
      if (bus.load[3] && !nop1) r_d[3] = alu1_y;
      if (bus.load[4] && !nop2) r_d[4] = alu2_y;
    end
    r4_write     = !contention && bus.load[4] && !nop2;
    dout_valid_d = r4_write;
    nop_err      = ((bus.load[2] | bus.load[3]) & nop1) | (bus.load[4] & nop2);
  end

  // Sequence monitor: the first step after reset is free.
  // After that, each step must repeat, advance by one, or restart at 0.
  always_comb begin
    seq_err = (bus.count > 4'd9);
    if (seq_q == SEQ_TRACK && bus.count != prev_q &&
        bus.count != prev_q + 4'd1 && bus.count != 4'd0)
      seq_err = 1'b1;
    seq_d      = SEQ_TRACK;
    prev_d     = bus.count;
    err_code_d = err_code_q | {seq_err, nop_err, contention};
  end

  // State registers.
  // Reset overrides every simultaneous load, select and count input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      // NOTE: the register file is reset entry by entry; the reset value is architecturally visible on dout.
      for (int i = 0; i < 5; i++) r_q[i] <= '0;
      dout_valid_q <= 1'b0;
      err_code_q   <= '0;
      seq_q        <= SEQ_FIRST;
      prev_q       <= '0;
    end else begin
      for (int i = 0; i < 5; i++) r_q[i] <= r_d[i];
      dout_valid_q <= dout_valid_d;
      err_code_q   <= err_code_d;
      seq_q        <= seq_d;
      prev_q       <= prev_d;
    end
  end

  assign bus.dout       = r_q[4];
  assign bus.dout_valid = dout_valid_q;
  assign bus.err_code   = err_code_q;
  assign bus.err        = |err_code_q;
endmodule

// File: tb/tb_pipe_datapath.sv
// Self-checking bench for pipe_datapath.
// A behavioural model runs on plain integers: register values, sticky
// error flags, and the previous step number.
// Directed scenarios and randomized batches are compared against that model.
module tb_pipe_datapath;
  logic clk = 1'b0;
  logic reset;
  pipe_datapath_if bus ();

  pipe_datapath u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_r [5];
  logic [2:0] m_err;
  logic       m_valid;
  bit         m_first;
  int         m_prev;
  int         last_count;

  // Folds any integer into the 10-bit two's complement range
  function automatic int wrap10(input int v);
    int m;
    m = v & 1023;
    if (m >= 512) m -= 1024;
    return m;
  endfunction

  function automatic int sel(input logic [2:0] s, input int x, input int y, input int z);
    case (s)
      3'b001:  return x;
      3'b010:  return y;
      3'b100:  return z;
      default: return 0;
    endcase
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Advances the model by one clock, using the inputs present at the edge
  task automatic model_step();
    int a, b, o1a, o1b, o2a, o2b, y1, y2, cnt;
    bit cont, nop, bad;
    if (reset) begin
      m_r     = '{default: 0};
      m_err   = 3'b000;
      m_valid = 1'b0;
      m_first = 1'b1;
      m_prev  = 0;
      return;
    end
    a   = int'(bus.din_a);
    b   = int'(bus.din_b);
    o1a = sel(bus.oe[2:0], m_r[0], m_r[1], a);
    o1b = sel(bus.oe[5:3], m_r[0], m_r[1], b);
    o2a = sel(bus.oe[8:6], m_r[2], m_r[3], m_r[4]);
    o2b = sel(bus.oe[11:9], m_r[2], m_r[3] >>> 1, m_r[2] >>> 3);
    cont = ($countones(bus.oe[2:0]) > 1) || ($countones(bus.oe[5:3]) > 1) ||
           ($countones(bus.oe[8:6]) > 1) || ($countones(bus.oe[11:9]) > 1);
    case (bus.c1)
      2'd0:    y1 = (o1a < 0) ? -o1a : o1a;
      2'd1:    y1 = imin(o1a, o1b);
      2'd2:    y1 = imax(o1a, o1b);
      default: y1 = 0;
    endcase
    case (bus.c2)
      2'd0:    y2 = o2a + o2b;
      2'd1:    y2 = o2a - o2b;
      2'd2:    y2 = imax(o2a, o2b);
      default: y2 = 0;
    endcase
    y1  = wrap10(y1);
    y2  = wrap10(y2);
    nop = ((bus.load[2] || bus.load[3]) && bus.c1 == 2'd3) || (bus.load[4] && bus.c2 == 2'd3);
    cnt = int'(bus.count);
    bad = (cnt > 9) || (!m_first && !(cnt == m_prev || cnt == m_prev + 1 || cnt == 0));
    m_err   = m_err | {bad, nop, cont};
    m_valid = 1'b0;
    if (!cont) begin
      if (bus.load[0]) m_r[0] = (bus.c1 == 2'd3) ? a : y1;
      if (bus.load[1]) m_r[1] = (bus.c1 == 2'd3) ? b : y1;
      if (bus.load[2] && bus.c1 != 2'd3) m_r[2] = y1;
      if (bus.load[3] && bus.c1 != 2'd3) m_r[3] = y1;
      if (bus.load[4] && bus.c2 != 2'd3) begin
        m_r[4]  = y2;
        m_valid = 1'b1;
      end
    end
    m_prev  = cnt;
    m_first = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [4:0] ld, input logic [11:0] o, input logic [1:0] op1,
                       input logic [1:0] op2, input int a, input int b);
    bus.load  = ld;
    bus.oe    = o;
    bus.c1    = op1;
    bus.c2    = op2;
    bus.din_a = 8'(a);
    bus.din_b = 8'(b);
  endtask

  task automatic set_idle();
    drive(5'b00000, 12'h000, 2'b00, 2'b00, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    bus.count = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  // Copies R2 into R4 (R4 <- R2 + 0), making R2 observable on dout
  task automatic show_r2();
    drive(5'b10000, {3'b000, 3'b001, 6'b0}, 2'b00, 2'b00, 0, 0);
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'b11111, 12'hfff, 2'b11, 2'b11, -1, -1);
    bus.count = 4'd15;
    tick();
    tick();
    if (bus.dout !== 10'sd0) begin
      n_errors++;
      $display("FAIL reset_dout: got %0d want 0", bus.dout);
    end
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got valid=%b err=%b code=%b want 0 0 000",
               bus.dout_valid, bus.err, bus.err_code);
    end
    n_checks++;
    reset = 1'b0;
    set_idle();
    bus.count = 4'd0;
  endtask

  task automatic test_pair_load();
    do_reset();
    drive(5'b00011, 12'h000, 2'b11, 2'b00, -5, 3);
    tick();
    if (bus.err !== 1'b0) begin
      n_errors++;
      $display("FAIL pair_err: got %b want 0", bus.err);
    end
    n_checks++;
    // R2 <- max(R0, -128), then R2 -> R4
    drive(5'b00100, {6'b0, 3'b100, 3'b001}, 2'b10, 2'b00, 0, -128);
    tick();
    show_r2();
    if (bus.dout !== 10'(m_r[4])) begin
      n_errors++;
      $display("FAIL pair_r0: got %0d want %0d", bus.dout, m_r[4]);
    end
    n_checks++;
    // R2 <- max(R1, -128), then R2 -> R4
    drive(5'b00100, {6'b0, 3'b100, 3'b010}, 2'b10, 2'b00, 0, -128);
    tick();
    show_r2();
    if (bus.dout !== 10'(m_r[4])) begin
      n_errors++;
      $display("FAIL pair_r1: got %0d want %0d", bus.dout, m_r[4]);
    end
    n_checks++;
  endtask

  task automatic test_magnitude();
    logic [11:0] r4_ops [3];
    r4_ops[0] = {3'b100, 3'b001, 6'b0};   // R2 - (R2>>>3)
    r4_ops[1] = {3'b010, 3'b100, 6'b0};   // R4 + (R3>>>1)
    r4_ops[2] = {3'b001, 3'b100, 6'b0};   // max(R4, R2)
    do_reset();
    drive(5'b00011, 12'h000, 2'b11, 2'b00, -5, 3);     tick();
    drive(5'b00001, {9'b0, 3'b001}, 2'b00, 2'b00, 0, 0); tick();
    drive(5'b00010, {9'b0, 3'b010}, 2'b00, 2'b00, 0, 0); tick();
    drive(5'b01000, {6'b0, 3'b010, 3'b001}, 2'b01, 2'b00, 0, 0); tick();
    drive(5'b00100, {6'b0, 3'b010, 3'b001}, 2'b10, 2'b00, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(5'b10000, r4_ops[k], 2'b00, (k == 0) ? 2'b01 : (k == 1) ? 2'b00 : 2'b10, 0, 0);
      tick();
      if (bus.dout !== 10'(m_r[4]) || bus.dout_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL mag_step%0d: got dout=%0d valid=%b want %0d 1",
                 k, bus.dout, bus.dout_valid, m_r[4]);
      end
      n_checks++;
    end
    set_idle();
    tick();
    if (bus.dout_valid !== 1'b0 || bus.dout !== 10'(m_r[4]) || bus.err_code !== 3'b000) begin
      n_errors++;
      $display("FAIL mag_idle: got valid=%b dout=%0d code=%b want 0 %0d 000",
               bus.dout_valid, bus.dout, bus.err_code, m_r[4]);
    end
    n_checks++;
  endtask

  task automatic test_contention();
    do_reset();
    drive(5'b00100, {9'b0, 3'b100}, 2'b00, 2'b00, 7, 0);
    tick();
    drive(5'b00100, 12'b000000000011, 2'b00, 2'b00, 0, 0);
    tick();
    if (bus.err_code !== 3'b001 || bus.err !== 1'b1) begin
      n_errors++;
      $display("FAIL cont_code: got %b err=%b want 001 1", bus.err_code, bus.err);
    end
    n_checks++;
    set_idle();
    for (int k = 0; k < 10; k++) tick();
    if (bus.err_code !== 3'b001) begin
      n_errors++;
      $display("FAIL cont_sticky: got %b want 001", bus.err_code);
    end
    n_checks++;
    show_r2();
    if (bus.dout !== 10'(m_r[4]) || bus.dout_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL cont_r2_held: got dout=%0d valid=%b want %0d 1", bus.dout, bus.dout_valid, m_r[4]);
    end
    n_checks++;
  endtask

  task automatic test_noop();
    do_reset();
    drive(5'b00100, {9'b0, 3'b100}, 2'b00, 2'b00, 9, 0);
    tick();
    show_r2();
    drive(5'b10000, {3'b000, 3'b001, 6'b0}, 2'b00, 2'b11, 0, 0);
    tick();
    if (bus.dout !== 10'(m_r[4]) || bus.dout_valid !== 1'b0 || bus.err_code !== 3'b010) begin
      n_errors++;
      $display("FAIL noop_r4: got dout=%0d valid=%b code=%b want %0d 0 010",
               bus.dout, bus.dout_valid, bus.err_code, m_r[4]);
    end
    n_checks++;
    // R2 write with c1 = 11 must hold R2
    drive(5'b00100, {9'b0, 3'b100}, 2'b11, 2'b00, 50, 0);
    tick();
    show_r2();
    if (bus.dout !== 10'(m_r[4]) || bus.err_code !== 3'b010) begin
      n_errors++;
      $display("FAIL noop_r2: got dout=%0d code=%b want %0d 010", bus.dout, bus.err_code, m_r[4]);
    end
    n_checks++;
  endtask

  task automatic run_counts(input string name, input int vals [$]);
    foreach (vals[k]) begin
      bus.count = 4'(vals[k]);
      tick();
      if (bus.err_code !== m_err) begin
        n_errors++;
        $display("FAIL %s[%0d]: got %b want %b", name, k, bus.err_code, m_err);
      end
      n_checks++;
    end
  endtask

  task automatic test_sequence();
    do_reset();
    run_counts("seq_skip", '{0, 1, 2, 4});
    do_reset();
    run_counts("seq_legal", '{0, 1, 1, 2, 0, 1});
    do_reset();
    run_counts("seq_range", '{12});
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.count = 4'd3;
    drive(5'b00100, {9'b0, 3'b100}, 2'b00, 2'b00, 7, 0);
    tick();
    show_r2();
    if (bus.dout !== 10'sd7 || bus.dout !== 10'(m_r[4])) begin
      n_errors++;
      $display("FAIL rst_mid_pre: got %0d want 7", bus.dout);
    end
    n_checks++;
    drive(5'b10000, {3'b000, 3'b001, 6'b0}, 2'b00, 2'b11, 0, 0);
    tick();
    // Reset lands on a cycle that would otherwise write R4 and break the sequence
    reset = 1'b1;
    drive(5'b10000, {3'b000, 3'b001, 6'b0}, 2'b00, 2'b00, 0, 0);
    bus.count = 4'd15;
    tick();
    reset = 1'b0;
    set_idle();
    bus.count = 4'd5;
    if (bus.dout !== 10'sd0 || bus.dout_valid !== 1'b0 || bus.err_code !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_mid: got dout=%0d valid=%b code=%b want 0 0 000",
               bus.dout, bus.dout_valid, bus.err_code);
    end
    n_checks++;
    tick();
    if (bus.err_code !== 3'b000 || bus.dout_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_first: got code=%b valid=%b want 000 0", bus.err_code, bus.dout_valid);
    end
    n_checks++;
  endtask

  function automatic logic [2:0] rand_grp();
    int r;
    r = $urandom_range(0, 39);
    if (r == 39) return 3'($urandom_range(0, 7));
    case (r % 4)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic test_random();
    int r;
    for (int batch = 0; batch < 4; batch++) begin
      do_reset();
      last_count = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        drive(5'($urandom_range(0, 31)),
              {rand_grp(), rand_grp(), rand_grp(), rand_grp()},
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 255), $urandom_range(0, 255));
        r = $urandom_range(0, 31);
        if (r < 12)      last_count = last_count;
        else if (r < 24) last_count = (last_count < 9) ? last_count + 1 : 0;
        else if (r < 31) last_count = 0;
        else             last_count = $urandom_range(0, 15);
        bus.count = 4'(last_count);
        tick();
        if (bus.dout !== 10'(m_r[4]) || bus.dout_valid !== m_valid ||
            bus.err_code !== m_err || bus.err !== (|m_err)) begin
          n_errors++;
          $display("FAIL rand_b%0d_c%0d: got dout=%0d valid=%b code=%b want %0d %b %b",
                   batch, cyc, bus.dout, bus.dout_valid, bus.err_code, m_r[4], m_valid, m_err);
        end
        n_checks++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    bus.count = 4'd0;
    m_r = '{default: 0};
    m_err = 3'b000;
    m_valid = 1'b0;
    m_first = 1'b1;
    m_prev = 0;
    test_reset();
    test_pair_load();
    test_magnitude();
    test_contention();
    test_noop();
    test_sequence();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
